// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants shared by the sync generator, the renderer
// and the testbench, plus the registered control-bit bundle.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam logic SYNC_POL = 1'b0;
  localparam int   CNT_W    = 10;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic frame_start;
    logic line_end;
  } vga_ctrl_t;

  function automatic logic in_window(input int unsigned value,
                                     input int unsigned first,
                                     input int unsigned last);
    return (value >= first) && (value <= last);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with count enable; wrap flags the terminal count N-1.
module mod_n_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + W'(1);
    end
  end

  assign count = count_reg;
  assign wrap  = (count_reg == LAST);

endmodule

// File: rtl/vga_sync_generator.sv
// VGA sync/timing generator: two wrapping counters, a compare decode of their
// state and a registered output bank (one cycle behind the counters).
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK    = vga_timing_pkg::H_BACK,
  parameter int   V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK    = vga_timing_pkg::V_BACK,
  parameter logic SYNC_POL  = vga_timing_pkg::SYNC_POL,
  parameter int   CNT_W     = vga_timing_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             line_end
);

  localparam int LINE_LEN    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST    = H_DISPLAY + H_FRONT;
  localparam int HS_LAST     = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST    = V_DISPLAY + V_FRONT;
  localparam int VS_LAST     = VS_FIRST + V_SYNC - 1;

  if ((LINE_LEN - 1) >= (1 << CNT_W) || (FRAME_LINES - 1) >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("vga_sync_generator: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last_unused;

  mod_n_counter #(.N(LINE_LEN), .W(CNT_W)) u_h_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (enable),
    .count (h_cnt),
    .wrap  (h_last)
  );

  // Lines advance only on the enabled edge that wraps the horizontal counter.
  mod_n_counter #(.N(FRAME_LINES), .W(CNT_W)) u_v_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (enable & h_last),
    .count (v_cnt),
    .wrap  (v_last_unused)
  );

  vga_ctrl_t        ctrl_next;
  vga_ctrl_t        ctrl_reg;
  logic [CNT_W-1:0] pixel_x_reg;
  logic [CNT_W-1:0] pixel_y_reg;

  always_comb begin
    ctrl_next             = '0;
    ctrl_next.hsync       = in_window(32'(h_cnt), HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
    ctrl_next.vsync       = in_window(32'(v_cnt), VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
    ctrl_next.video_on    = (h_cnt < CNT_W'(H_DISPLAY)) && (v_cnt < CNT_W'(V_DISPLAY));
    ctrl_next.frame_start = (h_cnt == '0) && (v_cnt == '0);
    ctrl_next.line_end    = h_last;
  end

  // While frozen everything holds except the pulses, which must not repeat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_reg.hsync       <= ~SYNC_POL;
      ctrl_reg.vsync       <= ~SYNC_POL;
      ctrl_reg.video_on    <= 1'b0;
      ctrl_reg.frame_start <= 1'b0;
      ctrl_reg.line_end    <= 1'b0;
      pixel_x_reg          <= '0;
      pixel_y_reg          <= '0;
    end else if (enable) begin
      ctrl_reg    <= ctrl_next;
      pixel_x_reg <= h_cnt;
      pixel_y_reg <= v_cnt;
    end else begin
      ctrl_reg.frame_start <= 1'b0;
      ctrl_reg.line_end    <= 1'b0;
    end
  end

  assign hsync       = ctrl_reg.hsync;
  assign vsync       = ctrl_reg.vsync;
  assign video_on    = ctrl_reg.video_on;
  assign frame_start = ctrl_reg.frame_start;
  assign line_end    = ctrl_reg.line_end;
  assign pixel_x     = pixel_x_reg;
  assign pixel_y     = pixel_y_reg;

endmodule
